lpddr4_lite_ctrl: RTL and testbench

//   Upstream controller for the 32-bit LPDDR4 model in the SoC DRAM testbench. Accepts one word request at a time
//   on a valid/ready host port (from the AXI bridge) and sequences the active-low cs/ras/cas/we command pins,

---
 rtl/lpddr4_lite_ctrl.sv | 244 ++++++++++++++++++++++++
 tb/tb_lpddr4_lite_ctrl.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lpddr4_lite_ctrl.sv
// Single-outstanding host-to-LPDDR4 command sequencer with registered pins and read-latency capture.
// Optional read-modify-write for partial writes when DRAM_CTRL_RMW_EN is defined.
module lpddr4_lite_ctrl #(
   parameter int unsigned MEM_WORDS = 1024,
   parameter int unsigned ADDR_W    = 32,
   parameter int unsigned RD_LAT    = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   input  logic [3:0]        req_wstrb,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [31:0]       resp_rdata,
   output logic              resp_err,
   output logic              dram_cs,
   output logic              dram_ras,
   output logic              dram_cas,
   output logic              dram_we,
   output logic [13:0]       dram_addr,
   output logic [2:0]        dram_ba,
   inout  wire  [31:0]       dram_dq,
   output logic [3:0]        dram_dm,
   output logic              dram_dqs
);

   localparam int unsigned IDX_W = $clog2(MEM_WORDS);
   localparam int unsigned CNT_W = $clog2(RD_LAT + 1);

   typedef enum logic [2:0] {
      IDLE,
      CMD,
      RDWAIT,
      RESP
`ifdef DRAM_CTRL_RMW_EN
      , RMW_RD,
      RMW_WAIT,
      RMW_WR
`endif
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               op_we_q, op_we_d;
   logic               dq_oe_q, dq_oe_d;
   logic [31:0]        dq_out_q, dq_out_d;
   logic               ready_d, resp_valid_d, resp_err_d;
   logic [31:0]        resp_rdata_d;
   logic               cs_d, ras_d, cas_d, we_d, dqs_d;
   logic [13:0]        addr_d;
   logic [3:0]         dm_d;
   logic               addr_err_c;
   logic [13:0]        req_idx_c;

`ifdef DRAM_CTRL_RMW_EN
   logic [13:0]        word_q, word_d;
   logic [31:0]        wdata_q, wdata_d;
   logic [3:0]         wstrb_q, wstrb_d;
   logic [31:0]        merged_c;

   // New bytes where the strobe is set, captured device bytes elsewhere.
   always_comb begin
      merged_c = dram_dq;
      for (int b = 0; b < 4; b++) begin
         if (wstrb_q[b]) merged_c[b*8 +: 8] = wdata_q[b*8 +: 8];
      end
   end
`endif

   assign addr_err_c = (req_addr[1:0] != 2'b00) || (req_addr >= ADDR_W'(MEM_WORDS * 4));
   assign req_idx_c  = 14'(req_addr[IDX_W+1:2]);
   assign dram_dq    = dq_oe_q ? dq_out_q : {32{1'bz}};
   assign dram_ba    = 3'b000;

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      op_we_d      = op_we_q;
      resp_valid_d = resp_valid;
      resp_rdata_d = resp_rdata;
      resp_err_d   = resp_err;
      cs_d         = 1'b1;
      ras_d        = 1'b1;
      cas_d        = 1'b1;
      we_d         = 1'b1;
      addr_d       = '0;
      dm_d         = '0;
      dqs_d        = 1'b0;
      dq_oe_d      = 1'b0;
      dq_out_d     = '0;
`ifdef DRAM_CTRL_RMW_EN
      word_d       = word_q;
      wdata_d      = wdata_q;
      wstrb_d      = wstrb_q;
`endif
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               op_we_d      = req_we;
               resp_rdata_d = '0;
               resp_err_d   = 1'b0;
`ifdef DRAM_CTRL_RMW_EN
               word_d       = req_idx_c;
               wdata_d      = req_wdata;
               wstrb_d      = req_wstrb;
`endif
               if (addr_err_c) begin
                  state_d      = RESP;
                  resp_valid_d = 1'b1;
                  resp_err_d   = 1'b1;
               end else if (req_we && req_wstrb == 4'h0) begin
                  state_d      = RESP;
                  resp_valid_d = 1'b1;
`ifdef DRAM_CTRL_RMW_EN
               end else if (req_we && req_wstrb != 4'hF) begin
                  // Partial write starts with a read of the target word.
                  state_d = RMW_RD;
                  cs_d    = 1'b0;
                  ras_d   = 1'b0;
                  cas_d   = 1'b0;
                  addr_d  = req_idx_c;
`endif
               end else begin
                  state_d = CMD;
                  cs_d    = 1'b0;
                  ras_d   = 1'b0;
                  cas_d   = 1'b0;
                  we_d    = ~req_we;
                  addr_d  = req_idx_c;
                  if (req_we) begin
                     dq_oe_d  = 1'b1;
                     dq_out_d = req_wdata;
                     dm_d     = ~req_wstrb;
                     dqs_d    = 1'b1;
                  end
               end
            end
         end
         CMD: begin
            if (op_we_q) begin
               state_d      = RESP;
               resp_valid_d = 1'b1;
            end else begin
               state_d = RDWAIT;
               cnt_d   = CNT_W'(RD_LAT);
            end
         end
         RDWAIT: begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               state_d      = RESP;
               resp_valid_d = 1'b1;
               resp_rdata_d = dram_dq;
            end
         end
         RESP: begin
            if (resp_ready) begin
               state_d      = IDLE;
               resp_valid_d = 1'b0;
            end
         end
`ifdef DRAM_CTRL_RMW_EN
         RMW_RD: begin
            state_d = RMW_WAIT;
            cnt_d   = CNT_W'(RD_LAT);
         end
         RMW_WAIT: begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               state_d = RMW_WR;
               wdata_d = merged_c;
            end
         end
         RMW_WR: begin
            // Full-word write of the merged data; op_we_q steers CMD to RESP.
            state_d  = CMD;
            cs_d     = 1'b0;
            ras_d    = 1'b0;
            cas_d    = 1'b0;
            we_d     = 1'b0;
            addr_d   = word_q;
            dq_oe_d  = 1'b1;
            dq_out_d = wdata_q;
            dqs_d    = 1'b1;
         end
`endif
         default: state_d = IDLE;
      endcase
      ready_d = (state_d == IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         op_we_q    <= 1'b0;
         dq_oe_q    <= 1'b0;
         dq_out_q   <= '0;
         req_ready  <= 1'b1;
         resp_valid <= 1'b0;
         resp_rdata <= '0;
         resp_err   <= 1'b0;
         dram_cs    <= 1'b1;
         dram_ras   <= 1'b1;
         dram_cas   <= 1'b1;
         dram_we    <= 1'b1;
         dram_addr  <= '0;
         dram_dm    <= '0;
         dram_dqs   <= 1'b0;
`ifdef DRAM_CTRL_RMW_EN
         word_q     <= '0;
         wdata_q    <= '0;
         wstrb_q    <= '0;
`endif
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         op_we_q    <= op_we_d;
         dq_oe_q    <= dq_oe_d;
         dq_out_q   <= dq_out_d;
         req_ready  <= ready_d;
         resp_valid <= resp_valid_d;
         resp_rdata <= resp_rdata_d;
         resp_err   <= resp_err_d;
         dram_cs    <= cs_d;
         dram_ras   <= ras_d;
         dram_cas   <= cas_d;
         dram_we    <= we_d;
         dram_addr  <= addr_d;
         dram_dm    <= dm_d;
         dram_dqs   <= dqs_d;
`ifdef DRAM_CTRL_RMW_EN
         word_q     <= word_d;
         wdata_q    <= wdata_d;
         wstrb_q    <= wstrb_d;
`endif
      end
   end

endmodule

// File: tb/tb_lpddr4_lite_ctrl.sv
// Randomized bench for lpddr4_lite_ctrl: word-level device model, transaction-level reference memory
// and a per-cycle expectation queue checked on every falling edge.
module tb_lpddr4_lite_ctrl;

   localparam int unsigned MEM_WORDS = 1024;
   localparam int unsigned ADDR_W    = 32;
   localparam int unsigned RD_LAT    = 1;
`ifdef DRAM_CTRL_RMW_EN
   localparam bit RMW_EN = 1'b1;
`else
   localparam bit RMW_EN = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              rst;
   logic              req_valid, req_ready, req_we;
   logic [ADDR_W-1:0] req_addr;
   logic [31:0]       req_wdata;
   logic [3:0]        req_wstrb;
   logic              resp_valid, resp_ready, resp_err;
   logic [31:0]       resp_rdata;
   logic              dram_cs, dram_ras, dram_cas, dram_we, dram_dqs;
   logic [13:0]       dram_addr;
   logic [2:0]        dram_ba;
   logic [3:0]        dram_dm;
   wire  [31:0]       dram_dq;

   logic              dev_oe;
   logic [31:0]       dev_dq;
   logic [31:0]       dev_mem [MEM_WORDS];
   logic [31:0]       ref_mem [MEM_WORDS];

   assign dram_dq = dev_oe ? dev_dq : {32{1'bz}};
   pullup (dram_dq);

   always #5 clk = ~clk;

   lpddr4_lite_ctrl #(.MEM_WORDS(MEM_WORDS), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_addr(req_addr),
      .req_wdata(req_wdata), .req_wstrb(req_wstrb),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err),
      .dram_cs(dram_cs), .dram_ras(dram_ras), .dram_cas(dram_cas), .dram_we(dram_we),
      .dram_addr(dram_addr), .dram_ba(dram_ba), .dram_dq(dram_dq), .dram_dm(dram_dm), .dram_dqs(dram_dqs)
   );

   // Device: samples commands on the rising edge, stores writes whole (dm ignored), returns reads next cycle.
   always @(posedge clk) begin
      dev_oe <= 1'b0;
      if (!dram_cs && !dram_ras && !dram_cas) begin
         if (!dram_we) dev_mem[dram_addr[9:0]] <= dram_dq;
         else begin
            dev_oe <= 1'b1;
            dev_dq <= dev_mem[dram_addr[9:0]];
         end
      end
   end

   typedef struct packed {
      logic        ready;
      logic        rvalid;
      logic [3:0]  cmd;     // {cs, ras, cas, we}
      logic [13:0] addr;
      logic [3:0]  dm;
      logic        dqs;
      logic [1:0]  dqm;     // 0 released, 1 driven with dq, 2 device may drive
      logic [31:0] dq;
   } exp_t;

   exp_t        exp_q[$];
   exp_t        e;
   bit          pend, rp, chk_en;
   logic [31:0] exp_rdata, last_rdata, last_dq;
   logic        exp_err, last_err;
   logic [3:0]  last_cmd;
   logic [13:0] last_addr;
   int          vectors, miscompares;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
      vectors++;
      if (act !== expv) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
      end
   endtask

   function automatic exp_t idle_e();
      exp_t x;
      x = '0;
      x.ready = 1'b1;
      x.cmd = 4'hF;
      return x;
   endfunction

   function automatic exp_t busy_e(input logic [1:0] dqm);
      exp_t x;
      x = idle_e();
      x.ready = 1'b0;
      x.dqm = dqm;
      return x;
   endfunction

   function automatic exp_t cmd_e(input logic wr, input logic [13:0] a, input logic [31:0] d, input logic [3:0] dm);
      exp_t x;
      x = busy_e(wr ? 2'd1 : 2'd0);
      x.cmd = {3'b000, ~wr};
      x.addr = a;
      x.dq = d;
      x.dm = wr ? dm : 4'h0;
      x.dqs = wr;
      return x;
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] st);
      logic [31:0] m;
      m = old;
      for (int b = 0; b < 4; b++) if (st[b]) m[b*8 +: 8] = nw[b*8 +: 8];
      return m;
   endfunction

   // Per-cycle compare against the queued expectation, or the response/idle expectation.
   always @(negedge clk) begin
      if (chk_en) begin
         if (dram_cs == 1'b0) begin
            last_cmd  = {dram_cs, dram_ras, dram_cas, dram_we};
            last_addr = dram_addr;
            last_dq   = dram_dq;
         end
         rp = 1'b0;
         if (exp_q.size() > 0) e = exp_q.pop_front();
         else begin
            e = idle_e();
            if (pend) begin
               e.ready = 1'b0;
               e.rvalid = 1'b1;
               rp = 1'b1;
            end
         end
         chk("ctl", 64'({req_ready, resp_valid, dram_cs, dram_ras, dram_cas, dram_we, dram_dqs}),
             64'({e.ready, e.rvalid, e.cmd, e.dqs}));
         chk("addr_dm_ba", 64'({dram_addr, dram_dm, dram_ba}), 64'({e.addr, e.dm, 3'b000}));
         if (e.dqm == 2'd0) chk("dq_released", 64'(dram_dq), 64'hFFFF_FFFF);
         else if (e.dqm == 2'd1) chk("dq_write", 64'(dram_dq), 64'(e.dq));
         if (rp) begin
            chk("resp", 64'({resp_err, resp_rdata}), 64'({exp_err, exp_rdata}));
            last_rdata = resp_rdata;
            last_err   = resp_err;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                      input logic [3:0] st, input int hold, input bit junk);
      logic [9:0] idx;
      int         n;
      idx = addr[11:2];
      req_valid = 1'b1;
      req_we = we;
      req_addr = addr;
      req_wdata = wd;
      req_wstrb = st;
      step();
      req_valid = 1'b0;
      exp_rdata = '0;
      exp_err = 1'b0;
      if (addr[1:0] != 2'b00 || addr >= MEM_WORDS * 4) exp_err = 1'b1;
      else if (we && st == 4'h0) exp_err = 1'b0;
      else if (we && RMW_EN && st != 4'hF) begin
         exp_q.push_back(cmd_e(1'b0, 14'(idx), '0, '0));
         for (int k = 1; k <= int'(RD_LAT); k++) exp_q.push_back(busy_e(k == int'(RD_LAT) ? 2'd2 : 2'd0));
         exp_q.push_back(busy_e(2'd0));
         ref_mem[idx] = merge(ref_mem[idx], wd, st);
         exp_q.push_back(cmd_e(1'b1, 14'(idx), ref_mem[idx], 4'h0));
      end else if (we) begin
         exp_q.push_back(cmd_e(1'b1, 14'(idx), wd, ~st));
         ref_mem[idx] = wd;
      end else begin
         exp_q.push_back(cmd_e(1'b0, 14'(idx), '0, '0));
         for (int k = 1; k <= int'(RD_LAT); k++) exp_q.push_back(busy_e(k == int'(RD_LAT) ? 2'd2 : 2'd0));
         exp_rdata = ref_mem[idx];
      end
      pend = 1'b1;
      n = exp_q.size();
      repeat (n) step();
      if (junk) begin
         req_valid = 1'b1;
         req_we = 1'($urandom);
         req_addr = 32'($urandom_range(0, 63)) << 2;
         req_wdata = $urandom;
         req_wstrb = 4'hF;
      end
      repeat (hold) step();
      resp_ready = 1'b1;
      step();
      resp_ready = 1'b0;
      req_valid = 1'b0;
      pend = 1'b0;
   endtask

   task automatic rst_checks(input string nm);
      chk({nm, "_ctl"}, 64'({req_ready, resp_valid, resp_err, dram_cs, dram_ras, dram_cas, dram_we, dram_dqs}),
          64'({1'b1, 1'b0, 1'b0, 4'hF, 1'b0}));
      chk({nm, "_data"}, 64'({resp_rdata, dram_addr, dram_dm, dram_ba}), 64'd0);
      chk({nm, "_dq"}, 64'(dram_dq), 64'hFFFF_FFFF);
   endtask

   initial begin
      logic [31:0] a;
      logic [3:0]  s;
      int          r;
      vectors = 0; miscompares = 0;
      chk_en = 1'b0; pend = 1'b0; dev_oe = 1'b0; dev_dq = '0;
      rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
      resp_ready = 1'b0; last_cmd = 4'hF; last_addr = '0; last_dq = '0; last_rdata = '0; last_err = 1'b0;
      exp_rdata = '0; exp_err = 1'b0;
      for (int i = 0; i < int'(MEM_WORDS); i++) begin
         dev_mem[i] = 32'(i) * 32'h9E37_79B9;
         ref_mem[i] = 32'(i) * 32'h9E37_79B9;
      end
      #3 rst = 1'b1;
      #1 rst_checks("reset");
      chk_en = 1'b1;
      repeat (2) step();
      rst = 1'b0;

      txn(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 0, 1'b0);
      chk("t2_cmd_lit", 64'({last_cmd, last_addr, last_dq}), 64'({4'b0000, 14'h004, 32'hDEAD_BEEF}));
      txn(1'b0, 32'h0000_0010, 32'h0, 4'h0, 0, 1'b0);
      chk("t3_cmd_lit", 64'({last_cmd, last_addr}), 64'({4'b0001, 14'h004}));
      chk("t3_rdata_lit", 64'({last_err, last_rdata}), 64'({1'b0, 32'hDEAD_BEEF}));

      last_cmd = 4'hF;
      txn(1'b0, 32'h0000_1000, 32'h0, 4'h0, 1, 1'b0);
      chk("t4_oor_lit", 64'({last_cmd, last_err, last_rdata}), 64'({4'hF, 1'b1, 32'h0}));
      txn(1'b0, 32'h0000_0002, 32'h0, 4'h0, 0, 1'b0);
      chk("t4_mis_lit", 64'({last_cmd, last_err, last_rdata}), 64'({4'hF, 1'b1, 32'h0}));

      txn(1'b0, 32'h0000_0010, 32'h0, 4'h0, 5, 1'b1);
      chk("t5_hold_lit", 64'(last_rdata), 64'h0000_0000_DEAD_BEEF);

      txn(1'b1, 32'h0000_0040, 32'h1122_3344, 4'hF, 0, 1'b0);
      txn(1'b1, 32'h0000_0040, 32'hAABB_CCDD, 4'b0101, 0, 1'b0);
      txn(1'b0, 32'h0000_0040, 32'h0, 4'h0, 0, 1'b0);
`ifdef DRAM_CTRL_RMW_EN
      chk("t6_merge_lit", 64'(last_rdata), 64'h0000_0000_11BB_33DD);
`else
      chk("t6_merge_lit", 64'(last_rdata), 64'h0000_0000_AABB_CCDD);
`endif

      // Reset one cycle after a read is accepted.
      req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0000_0010;
      step();
      req_valid = 1'b0;
      chk("t1_pre_cmd", 64'({dram_cs, dram_ras, dram_cas, dram_we, req_ready}), 64'({4'b0001, 1'b0}));
      rst = 1'b1;
      #1 rst_checks("t1_rst");
      repeat (2) step();
      rst = 1'b0;
      step();

      for (int t = 0; t < 200; t++) begin
         r = $urandom_range(0, 9);
         if (r == 0) a = (32'($urandom_range(0, MEM_WORDS - 1)) << 2) | 32'($urandom_range(1, 3));
         else if (r == 1) a = MEM_WORDS * 4 + (32'($urandom_range(0, 4095)) << 2);
         else if (r < 6) a = 32'($urandom_range(0, 31)) << 2;
         else a = 32'($urandom_range(0, MEM_WORDS - 1)) << 2;
         r = $urandom_range(0, 9);
         if (r < 2) s = 4'h0;
         else if (r < 5) s = 4'hF;
         else s = 4'($urandom);
         txn(1'($urandom), a, $urandom, s, $urandom_range(0, 3), 1'($urandom));
      end
      step();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
